// File: rtl/sum_accumulator.sv
// Frame accumulator behind the 8-bit adder: sums COUNT samples into a saturating
// ACC_W-bit total and hands each total downstream over a valid/ready handshake.
module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int COUNT  = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int              CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             out_valid_reg, out_valid_next;
  logic [ACC_W-1:0] out_data_reg, out_data_next;
  logic             out_ovf_reg, out_ovf_next;

  logic [ACC_W:0]   sum_wide;
  logic             sum_carry;
  logic [ACC_W-1:0] sum_sat;
  logic             sample_fire;
  logic             frame_fire;
  logic             last_sample;

  // One spare bit catches the carry; a saturated acc plus anything nonzero carries again.
  assign sum_wide  = {1'b0, acc_reg} + (ACC_W + 1)'(in_data);
  assign sum_carry = sum_wide[ACC_W];
  assign sum_sat   = sum_carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  assign in_ready    = (state_reg != HOLD);
  assign sample_fire = in_valid && in_ready;
  assign frame_fire  = out_valid_reg && out_ready;
  assign last_sample = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ovf_next   = out_ovf_reg;

    if (clear) begin
      // Abort wins over any handshake this cycle; the last published total stays readable.
      state_next     = IDLE;
      acc_next       = '0;
      cnt_next       = '0;
      ovf_next       = 1'b0;
      out_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (sample_fire) begin
            if (last_sample) begin
              state_next     = HOLD;
              acc_next       = '0;
              cnt_next       = '0;
              ovf_next       = 1'b0;
              out_valid_next = 1'b1;
              out_data_next  = sum_sat;
              out_ovf_next   = ovf_reg | sum_carry;
            end else begin
              state_next = ACCUM;
              acc_next   = sum_sat;
              cnt_next   = cnt_reg + 1'b1;
              ovf_next   = ovf_reg | sum_carry;
            end
          end
        end
        HOLD: begin
          if (frame_fire) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
          end
        end
        default: begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ovf_reg   <= out_ovf_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 10-bit and a 9-bit instance share one stimulus
// stream; the 9-bit one exposes saturation.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_ovf;

  logic       in_ready9;
  logic       out_valid9;
  logic [8:0] out_data9;
  logic       out_ovf9;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.DATA_W(8), .COUNT(4), .ACC_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  sum_accumulator #(.DATA_W(8), .COUNT(4), .ACC_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
    .out_valid(out_valid9), .out_ready(out_ready),
    .out_data(out_data9), .out_ovf(out_ovf9)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;

    // 1 reset with in_valid asserted
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h000);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // 2 basic frame, consumer always ready
    out_ready = 1'b1;
    push(8'h09);
    chk("basic_no_early_1", 32'(out_valid), 32'd0);
    push(8'h00);
    push(8'hFF);
    chk("basic_no_early_3", 32'(out_valid), 32'd0);
    push(8'h01);
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h109);
    chk("basic_ovf", 32'(out_ovf), 32'd0);
    chk("basic_data9", 32'(out_data9), 32'h109);
    chk("basic_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    chk("basic_valid_drop", 32'(out_valid), 32'd0);
    chk("basic_in_ready_back", 32'(in_ready), 32'd1);

    // 3 backpressure: 5th sample waits until the frame is taken
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h10);
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h040);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_taken", 32'(out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    push(8'h77);
    push(8'h01); push(8'h01); push(8'h01);
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'h07A);
    tick();

    // 4 saturation on the 9-bit instance, none on the 10-bit one
    for (int i = 0; i < 4; i++) push(8'hFF);
    in_valid = 1'b0;
    chk("sat_data9", 32'(out_data9), 32'h1FF);
    chk("sat_ovf9", 32'(out_ovf9), 32'd1);
    chk("sat_valid9", 32'(out_valid9), 32'd1);
    chk("nosat_data10", 32'(out_data), 32'h3FC);
    chk("nosat_ovf10", 32'(out_ovf), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) push(8'h01);
    in_valid = 1'b0;
    chk("post_sat_data9", 32'(out_data9), 32'h004);
    chk("post_sat_ovf9", 32'(out_ovf9), 32'd0);
    tick();

    // 5 gaps inside a frame
    push(8'h05);
    in_valid = 1'b0; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_no_valid", 32'(out_valid), 32'd0);
    end
    push(8'h04); push(8'h03); push(8'h02);
    in_valid = 1'b0;
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_data", 32'(out_data), 32'h00E);
    tick();

    // 6a clear mid-frame drops the partial sum and the simultaneous sample
    push(8'h20); push(8'h20);
    clear = 1'b1;
    push(8'h20);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h01);
    in_valid = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd1);
    chk("abort_data", 32'(out_data), 32'h004);
    tick();

    // 6b clear during HOLD, even with out_ready high
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h03);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", 32'(out_data), 32'h00C);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h40;
    tick();
    clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("hold_clear_valid", 32'(out_valid), 32'd0);
    chk("hold_clear_data_kept", 32'(out_data), 32'h00C);
    chk("hold_clear_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) push(8'h02);
    in_valid = 1'b0;
    chk("after_clear_data", 32'(out_data), 32'h008);
    out_ready = 1'b1;
    tick();

    // mid-frame reset clears the partial sum and the published total
    push(8'h10);
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_data", 32'(out_data), 32'h000);
    for (int i = 0; i < 4; i++) push(8'h01);
    in_valid = 1'b0;
    chk("midrst_frame_data", 32'(out_data), 32'h004);
    chk("midrst_frame_valid", 32'(out_valid), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
